// File: rtl/booth_divider_pkg.sv
// Shared definitions for the signed restoring divider: the default operand
// width and the controller state encoding.
package booth_divider_pkg;

    // Divisor/quotient/remainder width; the dividend is twice this wide.
    localparam int DW = 8;

    // Controller states.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] ADJ  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

endpackage

// File: rtl/booth_divider_div_controller.sv
// Sequencer for the divider: IDLE -> LOAD -> ITER (DW cycles) -> ADJ -> DONE.
// Emits one strobe per datapath action; every operation takes the same
// number of cycles, whatever the operands.
module div_controller
    import booth_divider_pkg::*;
#(
    parameter int DW = booth_divider_pkg::DW
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic capture,
    output logic load,
    output logic iter,
    output logic adj,
    output logic busy,
    output logic done
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] count;

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = ITER;
            ITER:    if (count == '0) state_next = ADJ;
            ADJ:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Iteration counter: armed in LOAD, counts down through ITER.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                              count <= '0;
        else if (state == LOAD)                 count <= CW'(DW - 1);
        else if (state == ITER && count != '0)  count <= count - 1'b1;
    end

    assign capture = (state == IDLE) && start;
    assign load    = (state == LOAD);
    assign iter    = (state == ITER);
    assign adj     = (state == ADJ);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: rtl/booth_divider.sv
// Signed 2*DW / DW divider. Restoring division on magnitudes, then sign
// fix-up: quotient truncates toward zero, remainder takes the dividend's sign.
// Divide-by-zero and out-of-range quotients force both results to zero.
module booth_divider
    import booth_divider_pkg::*;
#(
    parameter int DW = booth_divider_pkg::DW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2*DW-1:0] data_in1,
    input  logic [DW-1:0]   data_in2,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero,
    output logic            overflow
);

    // Largest positive quotient magnitude, and the magnitude of the most negative one.
    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MAG = {1'b1, {(DW-1){1'b0}}};

    // Magnitude of the dividend; the most negative value maps to 2^(2*DW-1).
    function automatic logic [2*DW-1:0] abs_dividend(input logic signed [2*DW-1:0] v);
        return v[2*DW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Magnitude of the divisor; -2^(DW-1) maps to 2^(DW-1).
    function automatic logic [DW-1:0] abs_divisor(input logic signed [DW-1:0] v);
        return v[DW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Two's-complement negate a magnitude when neg is set.
    function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    logic capture, load, iter, adj;

    logic signed [2*DW-1:0] dividend_reg;
    logic signed [DW-1:0]   divisor_reg;
    logic [DW:0]            rem_reg;
    logic [DW-1:0]          quo_reg;
    logic [DW-1:0]          bmag_reg;
    logic                   sa, sb, dz, ovf_pre;

    logic [2*DW-1:0] a_mag;
    logic [DW-1:0]   b_mag;
    logic [DW:0]     shifted;
    logic [DW:0]     diff;
    logic            fits;
    logic            neg;
    logic            ovf_now;

    div_controller #(.DW(DW)) u_ctrl (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .capture (capture),
        .load    (load),
        .iter    (iter),
        .adj     (adj),
        .busy    (busy),
        .done    (done)
    );

    assign a_mag   = abs_dividend(dividend_reg);
    assign b_mag   = abs_divisor(divisor_reg);

    // One restoring step: shift {R,Q} left, subtract |b| if it fits.
    assign shifted = {rem_reg[DW-1:0], quo_reg[DW-1]};
    assign fits    = (shifted >= {1'b0, bmag_reg});
    assign diff    = shifted - {1'b0, bmag_reg};

    // Range check of the signed quotient; ovf_pre already caught |q| >= 2^DW.
    assign neg     = sa ^ sb;
    assign ovf_now = ovf_pre
                   | (!neg && (quo_reg > POS_MAX))
                   | ( neg && (quo_reg > NEG_MAG));

    // Operand capture, magnitude/sign load and the iteration datapath.
    always_ff @(posedge clk) begin
        if (capture) begin
            dividend_reg <= $signed(data_in1);
            divisor_reg  <= $signed(data_in2);
        end
        if (load) begin
            rem_reg  <= {1'b0, a_mag[2*DW-1:DW]};
            quo_reg  <= a_mag[DW-1:0];
            bmag_reg <= b_mag;
            sa       <= dividend_reg[2*DW-1];
            sb       <= divisor_reg[DW-1];
            dz       <= (divisor_reg == '0);
            ovf_pre  <= (a_mag[2*DW-1:DW] >= b_mag);
        end else if (iter) begin
            rem_reg  <= fits ? diff : shifted;
            quo_reg  <= {quo_reg[DW-2:0], fits};
        end
    end

    // Result and flag registers, updated together once the magnitudes are final.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (adj) begin
            div_zero <= dz;
            overflow <= ovf_now;
            if (dz || ovf_now) begin
                quotient  <= '0;
                remainder <= '0;
            end else begin
                quotient  <= apply_sign(quo_reg, neg);
                remainder <= apply_sign(rem_reg[DW-1:0], sa);
            end
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed corner cases, reset abort,
// ignored mid-operation start, held-start back-to-back issue and random
// operands against an integer-arithmetic reference model.
module tb_booth_divider;

    localparam int DW  = 8;
    localparam int LAT = DW + 2;   // done seen after edge N+LAT
    localparam int GAP = DW + 4;   // LOAD + DW*ITER + ADJ + DONE + one IDLE re-sample

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic [2*DW-1:0] data_in1 = '0;
    logic [DW-1:0]   data_in2 = '0;
    logic            busy, done, div_zero, overflow;
    logic [DW-1:0]   quotient, remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_divider #(.DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer division (truncates toward zero, remainder
    // follows the dividend). A zero divisor also reports overflow, since the
    // dividend's high magnitude byte is always >= |0|.
    function automatic void model(input logic [2*DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] q, output logic [DW-1:0] r,
                                  output logic dz, output logic ov);
        int ai, bi, qt, rt;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            dz = 1'b1; ov = 1'b1; q = '0; r = '0;
        end else begin
            qt = ai / bi;
            rt = ai % bi;
            dz = 1'b0;
            ov = (qt < -(2 ** (DW-1))) || (qt > (2 ** (DW-1)) - 1);
            q  = ov ? '0 : DW'(qt);
            r  = ov ? '0 : DW'(rt);
        end
    endfunction

    task automatic run_op(input string tag, input logic [2*DW-1:0] a,
                          input logic [DW-1:0] b, input bit poke);
        logic [DW-1:0] eq, er;
        logic          edz, eov;
        int            seen;
        seen = 0;
        model(a, b, eq, er, edz, eov);
        @(negedge clk);
        data_in1 = a;
        data_in2 = b;
        start    = 1'b1;
        @(posedge clk);                    // edge N
        #1;
        start    = 1'b0;
        data_in1 = 16'($urandom);
        data_in2 = 8'($urandom);
        for (int k = 1; k <= LAT + 6 && seen == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = k;
            if (poke && k == 3) begin
                start    = 1'b1;
                data_in1 = 16'h1234;
                data_in2 = 8'h00;
            end
            if (poke && k == 4) start = 1'b0;
        end
        chk({tag, "_lat"},  seen,      LAT);
        chk({tag, "_q"},    quotient,  eq);
        chk({tag, "_r"},    remainder, er);
        chk({tag, "_dz"},   div_zero,  edz);
        chk({tag, "_ovf"},  overflow,  eov);
        chk({tag, "_busy"}, busy,      1);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int ndone, last, ndone_rst;
        logic [2*DW-1:0] ra;
        logic [DW-1:0]   rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q",    quotient, 0);
        chk("rst_r",    remainder, 0);
        chk("rst_dz",   div_zero, 0);
        chk("rst_ovf",  overflow, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed corners
        run_op("d500_7",   16'h01F4, 8'h07, 1'b0);
        run_op("dm500_7",  16'hFE0C, 8'h07, 1'b0);
        run_op("d500_m7",  16'h01F4, 8'hF9, 1'b0);
        run_op("d16k_m128",16'h4000, 8'h80, 1'b0);
        run_op("dm16k_m128",16'hC000, 8'h80, 1'b0);
        run_op("dzero",    16'h1234, 8'h00, 1'b0);
        run_op("dmax_1",   16'h7FFF, 8'h01, 1'b0);
        run_op("dmin_m1",  16'h8000, 8'hFF, 1'b0);
        run_op("dmin_m128",16'h8000, 8'h80, 1'b0);
        run_op("dm128_m128",16'hFF80, 8'h80, 1'b0);
        run_op("dm128_1",  16'hFF80, 8'h01, 1'b0);
        run_op("d127_1",   16'h007F, 8'h01, 1'b0);
        run_op("dpoke",    16'h01F4, 8'h07, 1'b1);

        // Reset during ITER: outputs clear immediately, no done afterwards
        run_op("pre_rst", 16'h01F4, 8'h07, 1'b0);
        @(negedge clk);
        data_in1 = 16'h01F4;
        data_in2 = 8'h07;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_q",    quotient, 0);
        chk("abort_r",    remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dz",   div_zero, 0);
        chk("abort_ovf",  overflow, 0);
        @(negedge clk);
        rstn = 1'b1;
        ndone_rst = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone_rst++;
        end
        chk("abort_nodone", ndone_rst, 0);
        run_op("reissue", 16'h01F4, 8'h07, 1'b0);

        // start held high: back-to-back results
        @(negedge clk);
        data_in1 = 16'h01F4;
        data_in2 = 8'h07;
        start    = 1'b1;
        ndone = 0;
        last  = -1;
        for (int t = 0; t < 4 * GAP; t++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (last >= 0) chk("b2b_gap", t - last, GAP);
                chk("b2b_q", quotient, 8'h47);
                chk("b2b_r", remainder, 8'h03);
                last = t;
                ndone++;
            end
        end
        chk("b2b_count", ndone, 4);
        start = 1'b0;
        repeat (GAP + 2) @(posedge clk);

        // Random operands against the model
        for (int i = 0; i < 2000; i++) begin
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0: ra = 16'($urandom);
                1: ra = {{DW{rb[0]}}, 8'($urandom)};
                default: ra = 16'(int'($signed(rb)) * (int'($urandom_range(0, 255)) - 128)
                                  + int'($urandom_range(0, 6)) - 3);
            endcase
            run_op("rand", ra, rb, ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
